// File: rtl/mux_arb4.sv
// Four-master round-robin arbiter with per-owner hold timeout and a one-cycle bubble between owners.
// sel is the registered owner index for an external 4:1 data mux; dbg_* expose FSM state and hold count.
module mux_arb4 #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic [3:0] done,
    output logic [3:0] grant,
    output logic [1:0] sel,
    output logic       busy,
    output logic       tmo,
    output logic       dbg_own,
    output logic [7:0] dbg_hold
);

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } state_t;

    localparam bit         TMO_EN   = (TIMEOUT != 0);
    localparam logic [7:0] TMO_LAST = TMO_EN ? 8'(TIMEOUT - 1) : 8'd0;

    state_t     state_q, state_d;
    logic [3:0] grant_q, grant_d;
    logic [1:0] sel_q, sel_d;
    logic [1:0] last_q, last_d;
    logic [7:0] cnt_q, cnt_d;
    logic       tmo_q, tmo_d;
    logic       busy_q, busy_d;

    logic [1:0] cand;
    logic [1:0] win_idx;
    logic       win_found;
    logic       owner_rel;
    logic       tmo_hit;

    // Round-robin search starting one past the last owner, wrapping at 4.
    always_comb begin
        cand      = last_q;
        win_idx   = last_q;
        win_found = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            cand = last_q + 2'(i);
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    assign owner_rel = done[sel_q] | ~req[sel_q];
    assign tmo_hit   = TMO_EN && (cnt_q == TMO_LAST);

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        sel_d   = sel_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        tmo_d   = 1'b0;
        case (state_q)
            IDLE: begin
                grant_d = 4'b0000;
                if (win_found) begin
                    state_d = OWN;
                    grant_d = 4'b0001 << win_idx;
                    sel_d   = win_idx;
                    last_d  = win_idx;
                    cnt_d   = 8'd0;
                end
            end
            OWN: begin
                cnt_d = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
                // A release on the timeout cycle wins over the timeout, so no tmo pulse.
                if (owner_rel || tmo_hit) begin
                    state_d = IDLE;
                    grant_d = 4'b0000;
                    cnt_d   = 8'd0;
                    tmo_d   = tmo_hit && !owner_rel;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = 4'b0000;
            end
        endcase
        busy_d = |grant_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= 4'b0000;
            sel_q   <= 2'd0;
            last_q  <= 2'd3;
            cnt_q   <= 8'd0;
            tmo_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            sel_q   <= sel_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            tmo_q   <= tmo_d;
            busy_q  <= busy_d;
        end
    end

    assign grant    = grant_q;
    assign sel      = sel_q;
    assign busy     = busy_q;
    assign tmo      = tmo_q;
    assign dbg_own  = (state_q == OWN);
    assign dbg_hold = cnt_q;

endmodule

// File: tb/tb_mux_arb4.sv
// Bench for mux_arb4: directed per-cycle vectors queued as expected outputs, checked by an independent monitor.
module tb_mux_arb4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [3:0] req_a, done_a, grant_a;
    logic [1:0] sel_a;
    logic       busy_a, tmo_a, own_a;
    logic [7:0] hold_a;
    logic [3:0] req_b, done_b, grant_b;
    logic [1:0] sel_b;
    logic       busy_b, tmo_b, own_b;
    logic [7:0] hold_b;

    mux_arb4 #(.TIMEOUT(4)) dut_a (
        .clk(clk), .rst(rst), .req(req_a), .done(done_a),
        .grant(grant_a), .sel(sel_a), .busy(busy_a), .tmo(tmo_a),
        .dbg_own(own_a), .dbg_hold(hold_a)
    );

    mux_arb4 #(.TIMEOUT(0)) dut_b (
        .clk(clk), .rst(rst), .req(req_b), .done(done_b),
        .grant(grant_b), .sel(sel_b), .busy(busy_b), .tmo(tmo_b),
        .dbg_own(own_b), .dbg_hold(hold_b)
    );

    // Entry: {id, hold_chk, grant[3:0], sel[1:0], busy, tmo, hold[7:0]}
    localparam int W = 18;
    logic [W-1:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs and queue the outputs expected after the next rising edge.
    task automatic cyc(input logic id, input logic rs, input logic [3:0] r, input logic [3:0] d,
                       input logic [3:0] g, input logic [1:0] s, input logic t,
                       input logic hchk, input logic [7:0] h);
        @(negedge clk);
        rst = rs;
        if (id == 1'b0) begin
            req_a = r; done_a = d; req_b = 4'h0; done_b = 4'h0;
        end else begin
            req_b = r; done_b = d; req_a = 4'h0; done_a = 4'h0;
        end
        exp_q.push_back({id, hchk, g, s, |g, t, h});
    endtask

    task automatic a(input logic [3:0] r, input logic [3:0] d, input logic [3:0] g,
                     input logic [1:0] s, input logic t);
        cyc(1'b0, 1'b0, r, d, g, s, t, 1'b0, 8'd0);
    endtask

    // Monitor
    initial begin
        logic [W-1:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                if (e[17] == 1'b0) begin
                    chk("grant_a", {4'h0, grant_a}, {4'h0, e[15:12]});
                    chk("sel_a", {6'h0, sel_a}, {6'h0, e[11:10]});
                    chk("busy_a", {7'h0, busy_a}, {7'h0, e[9]});
                    chk("tmo_a", {7'h0, tmo_a}, {7'h0, e[8]});
                    if (e[16]) chk("hold_a", hold_a, e[7:0]);
                end else begin
                    chk("grant_b", {4'h0, grant_b}, {4'h0, e[15:12]});
                    chk("sel_b", {6'h0, sel_b}, {6'h0, e[11:10]});
                    chk("busy_b", {7'h0, busy_b}, {7'h0, e[9]});
                    chk("tmo_b", {7'h0, tmo_b}, {7'h0, e[8]});
                    if (e[16]) chk("hold_b", hold_b, e[7:0]);
                end
            end
        end
    end

    // Driver
    initial begin
        logic [3:0] oh;
        rst = 1'b1;
        req_a = 4'h0; done_a = 4'h0; req_b = 4'h0; done_b = 4'h0;
        repeat (2) @(negedge clk);

        // Reset state with requests already high
        cyc(1'b0, 1'b1, 4'hF, 4'h0, 4'h0, 2'd0, 1'b0, 1'b1, 8'd0);

        // Full round robin, 3 grant cycles each, done in the third, bubble between owners
        for (int m = 0; m < 4; m++) begin
            oh = 4'b0001 << m;
            repeat (3) a(4'hF, 4'h0, oh, 2'(m), 1'b0);
            a(4'hF, oh, 4'h0, 2'(m), 1'b0);
        end
        a(4'hF, 4'h0, 4'h1, 2'd0, 1'b0);
        a(4'h0, 4'h0, 4'h0, 2'd0, 1'b0);

        // Timeout: 4 grant cycles, bubble with tmo, then re-grant
        repeat (4) a(4'h4, 4'h0, 4'h4, 2'd2, 1'b0);
        a(4'h4, 4'h0, 4'h0, 2'd2, 1'b1);
        a(4'h4, 4'h0, 4'h4, 2'd2, 1'b0);
        a(4'h0, 4'h0, 4'h0, 2'd2, 1'b0);

        // Non-owner done ignored; owner done on the timeout cycle is a normal release
        a(4'h1, 4'h0, 4'h1, 2'd0, 1'b0);
        a(4'h1, 4'h2, 4'h1, 2'd0, 1'b0);
        a(4'h1, 4'h2, 4'h1, 2'd0, 1'b0);
        a(4'h1, 4'h0, 4'h1, 2'd0, 1'b0);
        a(4'h1, 4'h1, 4'h0, 2'd0, 1'b0);

        // Owner 2 drops req with 1001 pending: 3 then 0
        a(4'h4, 4'h0, 4'h4, 2'd2, 1'b0);
        a(4'hD, 4'h0, 4'h4, 2'd2, 1'b0);
        a(4'h9, 4'h0, 4'h0, 2'd2, 1'b0);
        a(4'h9, 4'h0, 4'h8, 2'd3, 1'b0);
        a(4'h9, 4'h8, 4'h0, 2'd3, 1'b0);
        a(4'h9, 4'h0, 4'h1, 2'd0, 1'b0);
        a(4'h0, 4'h0, 4'h0, 2'd0, 1'b0);

        // Asynchronous reset mid-OWN
        a(4'h3, 4'h0, 4'h2, 2'd1, 1'b0);
        a(4'h3, 4'h0, 4'h2, 2'd1, 1'b0);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("async_grant", {4'h0, grant_a}, 8'h00);
        chk("async_busy", {7'h0, busy_a}, 8'h00);
        chk("async_tmo", {7'h0, tmo_a}, 8'h00);
        chk("async_sel", {6'h0, sel_a}, 8'h00);
        cyc(1'b0, 1'b1, 4'h3, 4'h0, 4'h0, 2'd0, 1'b0, 1'b0, 8'd0);
        a(4'h3, 4'h0, 4'h1, 2'd0, 1'b0);
        a(4'h0, 4'h0, 4'h0, 2'd0, 1'b0);

        // TIMEOUT=0: hold for 300 cycles, counter saturates, no tmo
        for (int i = 0; i < 300; i++) begin
            cyc(1'b1, 1'b0, 4'h1, 4'h0, 4'h1, 2'd0, 1'b0, 1'b1, (i > 255) ? 8'd255 : 8'(i));
        end
        cyc(1'b1, 1'b0, 4'h0, 4'h0, 4'h0, 2'd0, 1'b0, 1'b0, 8'd0);

        repeat (3) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mux_arb4.md
MUX_ARB4 -- requirements
Module: mux_arb4

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 16, giving the maximum cycles one requester may hold the grant; 0 disables the timeout; legal range 0..255.
REQ-002 The block SHALL have port clk, input, 1 bit: single clock, all state on the rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 The block SHALL have port req, input, 4 bits: request per master 0..3, held high while access is wanted.
REQ-005 The block SHALL have port done, input, 4 bits: single-cycle release strobe per master.
REQ-006 The block SHALL have port grant, output, 4 bits: one-hot grant, registered.
REQ-007 The block SHALL have port sel, output, 2 bits: encoded owner index, driving the select of the 4:1 32-bit data mux.
REQ-008 The block SHALL have port busy, output, 1 bit: high while any grant is asserted.
REQ-009 The block SHALL have port tmo, output, 1 bit: one-cycle pulse when a grant is revoked by timeout.

Function
REQ-010 The block SHALL implement a two-state FSM: IDLE (grant=0) and OWN (exactly one grant bit high).
REQ-011 In IDLE with req!=0, the block SHALL select a winner round-robin, searching from (last+1) mod 4 upward with wrap, and enter OWN next cycle; latency from req to grant is 1 cycle.
REQ-012 In IDLE with req=0, the block SHALL remain in IDLE with grant=0.
REQ-013 On entering OWN, the block SHALL set grant to the one-hot winner, sel to the winner index, last to the winner index, and the hold counter to 0.
REQ-014 sel SHALL change only on entry to OWN and SHALL hold its value through IDLE.
REQ-015 In OWN, the block SHALL increment an 8-bit hold counter each cycle, saturating at 255.
REQ-016 OWN SHALL exit to IDLE on the next edge when done[owner]=1, req[owner]=0, or (TIMEOUT!=0 and counter==TIMEOUT-1).
REQ-017 Every exit from OWN SHALL produce exactly one IDLE cycle with grant=0 (a one-cycle bubble) before any new grant.
REQ-018 done bits of non-owners SHALL be ignored, in any state.
REQ-019 tmo SHALL be 1 only during the IDLE cycle that follows a timeout exit.
REQ-020 When done[owner] or req[owner]=0 coincides with the timeout condition, the exit SHALL count as a normal release, with tmo=0.
REQ-021 busy SHALL equal OR of grant, registered, with no combinational path from req.
REQ-022 A requester that keeps req high after release SHALL be re-granted only after every other pending requester has been served once.

Reset
REQ-023 While rst=1, the block SHALL force: state=IDLE, grant=0000, sel=00, busy=0, tmo=0, counter=0, last=3, so master 0 has first priority.
REQ-024 Reset asserted during OWN SHALL drop grant asynchronously in the same instant, with no tmo pulse.
REQ-025 After rst deasserts, the first arbitration SHALL occur on the first rising edge.

Verification
REQ-026 The bench SHALL verify: after reset, req=1111 -> grants in the order 0001, 0010, 0100, 1000, 0001, each separated by one grant=0 cycle, while each owner pulses done after 3 cycles; sel follows 0,1,2,3,0.
REQ-027 The bench SHALL verify: TIMEOUT=4, req=0100 held with no done -> grant=0100 for exactly 4 cycles, then a grant=0 cycle with tmo=1, then grant=0100 again.
REQ-028 The bench SHALL verify: done=0010 while owner is master 0 -> ignored, grant stays 0001; and done=0001 coinciding with the timeout cycle -> tmo stays 0.
REQ-029 The bench SHALL verify: owner 2 drops req mid-hold with req=1001 pending -> next grant is 1000 (search starts at 3), then 0001.
REQ-030 The bench SHALL verify: rst asserted mid-OWN between clock edges -> grant=0000 and busy=0 immediately; after release with req=0011 -> first grant is 0001.
REQ-031 The bench SHALL verify: TIMEOUT=0, single requester holding for 300 cycles -> no tmo, grant held for the whole interval, counter saturated at 255.
